// File: rtl/lstm_sequencer.sv
// lstm_sequencer: host-side driver for one lstm cell. Routes config writes to
// the cell's weight/bias lanes, issues one sample at a time under the cell's
// ready rule (zeroing h/C at each sequence start), and buffers the cell
// results in a small first-word-fall-through FIFO with valid/ready output.
module lstm_sequencer #(
   parameter int WIDTH     = 16,
   parameter int OUT_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   // config write port
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [1:0]             cfg_sel,
   input  logic [1:0]             cfg_gate,
   input  logic [WIDTH-1:0]       cfg_data,
   // input sample stream
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [WIDTH-1:0]       s_data,
   input  logic                   s_last,
   // output result stream
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [WIDTH-1:0]       m_y,
   output logic [WIDTH-1:0]       m_c,
   output logic                   m_last,
   // cell parameter lanes, gate order i,f,g,o
   output logic [3:0][WIDTH-1:0]  lstm_weight_x,
   output logic [3:0][WIDTH-1:0]  lstm_weight_h,
   output logic [3:0][WIDTH-1:0]  lstm_bias_x,
   output logic [3:0][WIDTH-1:0]  lstm_bias_h,
   output logic [3:0]             lstm_weight_x_valid,
   output logic [3:0]             lstm_weight_h_valid,
   output logic [3:0]             lstm_bias_x_valid,
   output logic [3:0]             lstm_bias_h_valid,
   // cell data inputs
   output logic [WIDTH-1:0]       lstm_x_in,
   output logic [WIDTH-1:0]       lstm_h_in,
   output logic [WIDTH-1:0]       lstm_c_in,
   output logic                   lstm_x_in_valid,
   output logic                   lstm_h_in_valid,
   output logic                   lstm_c_in_valid,
   // cell results
   input  logic                   lstm_ready,
   input  logic [WIDTH-1:0]       lstm_y_out,
   input  logic [WIDTH-1:0]       lstm_c_out,
   input  logic                   lstm_valid,
   // status
   output logic                   busy,
   output logic [15:0]            seq_cnt,
   output logic                   err_unexpected
);

   localparam int WEIGHTS = 4;
   localparam int PW      = $clog2(OUT_DEPTH);

   logic              r_in_flight;
   logic              r_first;
   logic              r_tag_last;
   logic [PW:0]       r_count;
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [15:0]       r_seq_cnt;
   logic              r_err;
   logic [WIDTH-1:0]  r_mem_y    [OUT_DEPTH];
   logic [WIDTH-1:0]  r_mem_c    [OUT_DEPTH];
   logic              r_mem_last [OUT_DEPTH];

   logic              w_cfg_fire;
   logic              w_s_fire;
   logic              w_push;
   logic              w_pop;
   logic [WEIGHTS-1:0] w_lane_hit;

   // Config and samples both need an idle cell; config wins when both are offered.
   assign cfg_ready  = lstm_ready & ~r_in_flight;
   assign s_ready    = lstm_ready & ~r_in_flight
                       & (r_count < (PW+1)'(OUT_DEPTH)) & ~cfg_valid;
   assign w_cfg_fire = cfg_valid & cfg_ready;
   assign w_s_fire   = s_valid & s_ready;

   // A completion is only meaningful while a sample is outstanding.
   assign w_push     = lstm_valid & r_in_flight;
   assign m_valid    = (r_count != '0);
   assign w_pop      = m_valid & m_ready;

   // One-hot lane decode: only the addressed gate of the selected bank sees data.
   genvar gi;
   generate
      for (gi = 0; gi < WEIGHTS; gi++) begin : g_lane
         assign w_lane_hit[gi]          = w_cfg_fire && (cfg_gate == 2'(gi));
         assign lstm_weight_x_valid[gi] = w_lane_hit[gi] && (cfg_sel == 2'd0);
         assign lstm_weight_h_valid[gi] = w_lane_hit[gi] && (cfg_sel == 2'd1);
         assign lstm_bias_x_valid[gi]   = w_lane_hit[gi] && (cfg_sel == 2'd2);
         assign lstm_bias_h_valid[gi]   = w_lane_hit[gi] && (cfg_sel == 2'd3);
         assign lstm_weight_x[gi] = lstm_weight_x_valid[gi] ? cfg_data : '0;
         assign lstm_weight_h[gi] = lstm_weight_h_valid[gi] ? cfg_data : '0;
         assign lstm_bias_x[gi]   = lstm_bias_x_valid[gi]   ? cfg_data : '0;
         assign lstm_bias_h[gi]   = lstm_bias_h_valid[gi]   ? cfg_data : '0;
      end
   endgenerate

   // Sample drive: the first sample of a sequence also loads zero h/C.
   assign lstm_x_in_valid = w_s_fire;
   assign lstm_x_in       = w_s_fire ? s_data : '0;
   assign lstm_h_in_valid = w_s_fire & r_first;
   assign lstm_c_in_valid = w_s_fire & r_first;
   assign lstm_h_in       = '0;
   assign lstm_c_in       = '0;

   // FIFO head is presented directly; outputs read as zero when empty.
   assign m_y    = m_valid ? r_mem_y[r_rd_ptr]    : '0;
   assign m_c    = m_valid ? r_mem_c[r_rd_ptr]    : '0;
   assign m_last = m_valid ? r_mem_last[r_rd_ptr] : 1'b0;

   assign busy           = r_in_flight | m_valid;
   assign seq_cnt        = r_seq_cnt;
   assign err_unexpected = r_err;

   // Control state: in-flight tracking, sequence bookkeeping, FIFO pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_flight <= 1'b0;
         r_first     <= 1'b1;
         r_tag_last  <= 1'b0;
         r_count     <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_seq_cnt   <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_s_fire) begin
            r_in_flight <= 1'b1;
            r_tag_last  <= s_last;
            r_first     <= s_last;
         end else if (w_push) begin
            r_in_flight <= 1'b0;
         end
         if (w_push && r_tag_last)
            r_seq_cnt <= r_seq_cnt + 16'd1;
         if (lstm_valid && !r_in_flight)
            r_err <= 1'b1;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; validity is carried by the count, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_y[r_wr_ptr]    <= lstm_y_out;
         r_mem_c[r_wr_ptr]    <= lstm_c_out;
         r_mem_last[r_wr_ptr] <= r_tag_last;
      end
   end

endmodule

// File: tb/tb_lstm_sequencer.sv
// Testbench for lstm_sequencer: a timing stub of the lstm cell returns random
// results 7 cycles after each accepted sample; a queue of expected results
// and a sequence counter form the reference model.
module tb_lstm_sequencer;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               cfg_valid = 1'b0;
   logic               cfg_ready;
   logic [1:0]         cfg_sel = '0;
   logic [1:0]         cfg_gate = '0;
   logic [15:0]        cfg_data = '0;
   logic               s_valid = 1'b0;
   logic               s_ready;
   logic [15:0]        s_data = '0;
   logic               s_last = 1'b0;
   logic               m_valid;
   logic               m_ready = 1'b0;
   logic [15:0]        m_y, m_c;
   logic               m_last;
   logic [3:0][15:0]   lstm_weight_x, lstm_weight_h, lstm_bias_x, lstm_bias_h;
   logic [3:0]         lstm_weight_x_valid, lstm_weight_h_valid;
   logic [3:0]         lstm_bias_x_valid, lstm_bias_h_valid;
   logic [15:0]        lstm_x_in, lstm_h_in, lstm_c_in;
   logic               lstm_x_in_valid, lstm_h_in_valid, lstm_c_in_valid;
   logic               lstm_ready;
   logic [15:0]        lstm_y_out, lstm_c_out;
   logic               lstm_valid;
   logic               busy;
   logic [15:0]        seq_cnt;
   logic               err_unexpected;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int exp_seq = 0;

   typedef struct packed {
      logic [15:0] y;
      logic [15:0] c;
      logic        last;
   } ent_t;
   ent_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lstm_sequencer #(.WIDTH(16), .OUT_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
      .cfg_gate(cfg_gate), .cfg_data(cfg_data),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_c(m_c), .m_last(m_last),
      .lstm_weight_x(lstm_weight_x), .lstm_weight_h(lstm_weight_h),
      .lstm_bias_x(lstm_bias_x), .lstm_bias_h(lstm_bias_h),
      .lstm_weight_x_valid(lstm_weight_x_valid), .lstm_weight_h_valid(lstm_weight_h_valid),
      .lstm_bias_x_valid(lstm_bias_x_valid), .lstm_bias_h_valid(lstm_bias_h_valid),
      .lstm_x_in(lstm_x_in), .lstm_h_in(lstm_h_in), .lstm_c_in(lstm_c_in),
      .lstm_x_in_valid(lstm_x_in_valid), .lstm_h_in_valid(lstm_h_in_valid),
      .lstm_c_in_valid(lstm_c_in_valid),
      .lstm_ready(lstm_ready), .lstm_y_out(lstm_y_out), .lstm_c_out(lstm_c_out),
      .lstm_valid(lstm_valid),
      .busy(busy), .seq_cnt(seq_cnt), .err_unexpected(err_unexpected)
   );

   // ---------------- cell stub: 7-cycle latency, ready again at T+8 ----------------
   int          cell_cnt = 0;
   logic [15:0] cell_y = '0, cell_c = '0;
   logic [15:0] next_y = '0, next_c = '0;
   logic        stray_valid = 1'b0;

   always @(negedge clk) begin
      next_y <= 16'($urandom);
      next_c <= 16'($urandom);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cell_cnt <= 0;
      end else if (lstm_x_in_valid) begin
         cell_cnt <= 7;
         cell_y   <= next_y;
         cell_c   <= next_c;
         exp_q.push_back(ent_t'{next_y, next_c, s_last});
      end else if (cell_cnt != 0) begin
         cell_cnt <= cell_cnt - 1;
      end
   end

   assign lstm_ready = (cell_cnt == 0);
   assign lstm_valid = (cell_cnt == 1) || stray_valid;
   assign lstm_y_out = (cell_cnt == 1) ? cell_y : 16'h0;
   assign lstm_c_out = (cell_cnt == 1) ? cell_c : 16'h0;

   // ---------------- stimulus helpers ----------------
   // Offer one sample and report the accept cycle plus the cell drive seen then.
   task automatic offer(input logic [15:0] d, input logic last, output int acc,
                        output logic [2:0] v, output logic [15:0] hcd,
                        output logic [15:0] xo);
      int n;
      n = 0;
      @(negedge clk);
      s_valid = 1'b1; s_data = d; s_last = last;
      #1;
      while (!s_ready && n < 200) begin
         @(negedge clk); #1; n++;
      end
      acc = (n < 200) ? cyc : -1;
      v   = {lstm_x_in_valid, lstm_h_in_valid, lstm_c_in_valid};
      hcd = lstm_h_in | lstm_c_in;
      xo  = lstm_x_in;
      $display("accept cyc=%0d x=%h last=%b drive=%b", acc, d, last, v);
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   // Pop every outstanding result and compare with the expected queue.
   task automatic drain(input string tag);
      int   n;
      ent_t e;
      while (exp_q.size() > 0) begin
         n = 0;
         @(negedge clk); m_ready = 1'b1; #1;
         while (!m_valid && n < 200) begin
            @(negedge clk); #1; n++;
         end
         e = exp_q.pop_front();
         checks++;
         if (m_valid !== 1'b1 || m_y !== e.y || m_c !== e.c || m_last !== e.last) begin
            errors++;
            $display("FAIL %s_pop: got v=%b y=%h c=%h last=%b, expected y=%h c=%h last=%b",
                     tag, m_valid, m_y, m_c, m_last, e.y, e.c, e.last);
         end else begin
            $display("pop %s y=%h c=%h last=%b", tag, m_y, m_c, m_last);
         end
         @(posedge clk); #1;
         m_ready = 1'b0;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({m_valid, m_last, busy, err_unexpected} !== 4'b0 || m_y !== 16'h0 || m_c !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs: got m_valid=%b m_last=%b busy=%b err=%b y=%h c=%h, expected all 0",
                  m_valid, m_last, busy, err_unexpected, m_y, m_c);
      end
      checks++;
      if ({lstm_weight_x_valid, lstm_weight_h_valid, lstm_bias_x_valid, lstm_bias_h_valid,
           lstm_x_in_valid, lstm_h_in_valid, lstm_c_in_valid} !== 19'b0) begin
         errors++;
         $display("FAIL reset_lstm_valids: got nonzero, expected 0");
      end
      checks++;
      if (seq_cnt !== 16'h0) begin
         errors++; $display("FAIL reset_seq_cnt: got %h, expected 0000", seq_cnt);
      end
      checks++;
      if (s_ready !== 1'b1 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got s_ready=%b cfg_ready=%b, expected 1 1", s_ready, cfg_ready);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset released");
   endtask

   task automatic test_config();
      int               acc;
      logic [2:0]       v;
      logic [15:0]      hcd, xo;
      logic [1:0]       sel, gate;
      logic [15:0]      d;
      logic [3:0][3:0]  expv;
      logic [3:0][3:0][15:0] expd;
      @(negedge clk);
      cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_gate = 2'd1; cfg_data = 16'h0100;
      s_valid = 1'b1; s_data = 16'h1234; s_last = 1'b1;
      #1;
      checks++;
      if (lstm_weight_x_valid !== 4'b0010 || lstm_weight_x[1] !== 16'h0100 ||
          lstm_weight_x[0] !== 16'h0 || lstm_weight_x[2] !== 16'h0 || lstm_weight_x[3] !== 16'h0) begin
         errors++;
         $display("FAIL cfg_wx_gate1: got valid=%b lanes=%h, expected 0010 lane1=0100 others 0",
                  lstm_weight_x_valid, lstm_weight_x);
      end
      checks++;
      if (s_ready !== 1'b0 || lstm_x_in_valid !== 1'b0) begin
         errors++;
         $display("FAIL cfg_priority: got s_ready=%b x_valid=%b, expected 0 0", s_ready, lstm_x_in_valid);
      end
      $display("cfg sel=0 gate=1 data=0100 valid=%b", lstm_weight_x_valid);
      s_valid = 1'b0; s_last = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         sel = 2'($urandom_range(0, 3)); gate = 2'($urandom_range(0, 3)); d = 16'($urandom);
         cfg_valid = 1'b1; cfg_sel = sel; cfg_gate = gate; cfg_data = d;
         expv = '0; expd = '0;
         expv[sel][gate] = 1'b1;
         expd[sel][gate] = d;
         #1;
         checks++;
         if ({lstm_bias_h_valid, lstm_bias_x_valid, lstm_weight_h_valid, lstm_weight_x_valid} !== expv ||
             {lstm_bias_h, lstm_bias_x, lstm_weight_h, lstm_weight_x} !== expd) begin
            errors++;
            $display("FAIL cfg_rand: sel=%0d gate=%0d got valids=%h, expected %h", sel, gate,
                     {lstm_bias_h_valid, lstm_bias_x_valid, lstm_weight_h_valid, lstm_weight_x_valid}, expv);
         end else begin
            $display("cfg sel=%0d gate=%0d data=%h", sel, gate, d);
         end
      end
      @(negedge clk);
      cfg_valid = 1'b0;
      offer(16'h0042, 1'b1, acc, v, hcd, xo);
      @(negedge clk);
      cfg_valid = 1'b1; cfg_sel = 2'd2; cfg_gate = 2'd3; cfg_data = 16'hBEEF;
      #1;
      checks++;
      if (cfg_ready !== 1'b0 || lstm_bias_x_valid !== 4'b0) begin
         errors++;
         $display("FAIL cfg_inflight: got cfg_ready=%b bias_x_valid=%b, expected 0 0000",
                  cfg_ready, lstm_bias_x_valid);
      end
      cfg_valid = 1'b0;
      exp_seq++;
      drain("cfg");
   endtask

   task automatic test_sequence();
      logic [15:0] xs [3];
      int          acc [3];
      logic [2:0]  v, expd;
      logic [15:0] hcd, xo;
      xs[0] = 16'h0100; xs[1] = 16'h0080; xs[2] = 16'hFF00;
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         offer(xs[i], (i == 2), acc[i], v, hcd, xo);
         expd = (i == 0) ? 3'b111 : 3'b100;
         checks++;
         if (acc[i] < 0 || v !== expd || hcd !== 16'h0 || xo !== xs[i]) begin
            errors++;
            $display("FAIL seq_drive%0d: got acc=%0d drive=%b hc=%h x=%h, expected drive=%b hc=0000 x=%h",
                     i, acc[i], v, hcd, xo, expd, xs[i]);
         end
         if (i > 0) begin
            checks++;
            if (acc[i] - acc[i-1] != 8) begin
               errors++;
               $display("FAIL seq_spacing%0d: got %0d cycles, expected 8", i, acc[i] - acc[i-1]);
            end
         end
      end
      exp_seq++;
      drain("seq");
      checks++;
      if (seq_cnt !== 16'(exp_seq) || busy !== 1'b0) begin
         errors++;
         $display("FAIL seq_cnt: got seq_cnt=%0d busy=%b, expected %0d 0", seq_cnt, busy, exp_seq);
      end
   endtask

   task automatic test_idle_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (seq_cnt !== 16'h0 || m_valid !== 1'b0 || busy !== 1'b0 ||
          s_ready !== 1'b1 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_reset: got seq_cnt=%0d m_valid=%b busy=%b s_ready=%b cfg_ready=%b, expected 0 0 0 1 1",
                  seq_cnt, m_valid, busy, s_ready, cfg_ready);
      end
      exp_seq = 0;
      @(negedge clk);
      rst_n = 1'b1;
      $display("idle reset done");
   endtask

   task automatic test_backpressure();
      int accepts;
      ent_t e;
      accepts = 0;
      m_ready = 1'b0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         s_valid = 1'b1; s_data = 16'($urandom); s_last = 1'b1;
         #1;
         if (s_ready) begin
            accepts++;
            $display("bp accept %0d x=%h", accepts, s_data);
         end
      end
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
      #1;
      checks++;
      if (accepts != 4 || s_ready !== 1'b0 || m_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL bp_full: got accepts=%0d s_ready=%b m_valid=%b busy=%b, expected 4 0 1 1",
                  accepts, s_ready, m_valid, busy);
      end
      m_ready = 1'b1;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (m_y !== e.y || m_c !== e.c || m_last !== e.last) begin
         errors++;
         $display("FAIL bp_pop: got y=%h c=%h last=%b, expected y=%h c=%h last=%b",
                  m_y, m_c, m_last, e.y, e.c, e.last);
      end
      @(posedge clk); #1;
      m_ready = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (s_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release: got s_ready=%b, expected 1", s_ready);
      end
      exp_seq += 4;
      drain("bp");
      checks++;
      if (seq_cnt !== 16'(exp_seq)) begin
         errors++; $display("FAIL bp_seq_cnt: got %0d, expected %0d", seq_cnt, exp_seq);
      end
   endtask

   task automatic test_back_to_back();
      int          acc;
      logic [2:0]  v, expd;
      logic [15:0] hcd, xo, d;
      logic        lasts [3];
      int          base;
      lasts[0] = 1'b0; lasts[1] = 1'b1; lasts[2] = 1'b1;
      base = exp_seq;
      for (int i = 0; i < 3; i++) begin
         d = 16'($urandom);
         offer(d, lasts[i], acc, v, hcd, xo);
         expd = (i == 1) ? 3'b100 : 3'b111;
         checks++;
         if (acc < 0 || v !== expd || hcd !== 16'h0 || xo !== d) begin
            errors++;
            $display("FAIL b2b_drive%0d: got drive=%b hc=%h x=%h, expected drive=%b hc=0000 x=%h",
                     i, v, hcd, xo, expd, d);
         end
         if (i == 2) begin
            checks++;
            if (seq_cnt !== 16'(base + 1)) begin
               errors++; $display("FAIL b2b_mid_cnt: got %0d, expected %0d", seq_cnt, base + 1);
            end
         end
      end
      exp_seq += 2;
      drain("b2b");
      checks++;
      if (seq_cnt !== 16'(exp_seq)) begin
         errors++; $display("FAIL b2b_cnt: got %0d, expected %0d", seq_cnt, exp_seq);
      end
   endtask

   task automatic test_random();
      int          acc;
      logic [2:0]  v, expd;
      logic [15:0] hcd, xo, d;
      logic        l, mfirst;
      mfirst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         d = 16'($urandom);
         l = ($urandom_range(0, 2) == 0);
         offer(d, l, acc, v, hcd, xo);
         expd = mfirst ? 3'b111 : 3'b100;
         checks++;
         if (acc < 0 || v !== expd || hcd !== 16'h0 || xo !== d) begin
            errors++;
            $display("FAIL rand_drive%0d: got drive=%b hc=%h x=%h, expected drive=%b hc=0000 x=%h",
                     i, v, hcd, xo, expd, d);
         end
         if (l) exp_seq++;
         mfirst = l;
         if (exp_q.size() >= 3 || i == 11) drain("rand");
      end
      // close any open sequence so later tests start fresh
      if (!mfirst) begin
         offer(16'h0001, 1'b1, acc, v, hcd, xo);
         exp_seq++;
         drain("rand");
      end
      checks++;
      if (seq_cnt !== 16'(exp_seq) || busy !== 1'b0) begin
         errors++;
         $display("FAIL rand_cnt: got seq_cnt=%0d busy=%b, expected %0d 0", seq_cnt, busy, exp_seq);
      end
   endtask

   task automatic test_async_reset();
      int          acc;
      logic [2:0]  v;
      logic [15:0] hcd, xo;
      offer(16'h0777, 1'b1, acc, v, hcd, xo);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      exp_q.delete();
      exp_seq = 0;
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0 || err_unexpected !== 1'b0 || seq_cnt !== 16'h0) begin
         errors++;
         $display("FAIL areset_flush: got m_valid=%b busy=%b err=%b seq_cnt=%0d, expected 0 0 0 0",
                  m_valid, busy, err_unexpected, seq_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      stray_valid = 1'b1;
      #1;
      checks++;
      if (err_unexpected !== 1'b0) begin
         errors++; $display("FAIL areset_err_early: got %b, expected 0", err_unexpected);
      end
      @(posedge clk); #1;
      stray_valid = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (err_unexpected !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL areset_stray: got err=%b m_valid=%b busy=%b, expected 1 0 0",
                  err_unexpected, m_valid, busy);
      end
      $display("stray pulse dropped err=%b", err_unexpected);
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (err_unexpected !== 1'b1) begin
         errors++; $display("FAIL areset_sticky: got %b, expected 1", err_unexpected);
      end
   endtask

   initial begin
      test_reset();
      test_config();
      test_sequence();
      test_idle_reset();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lstm_sequencer.md
# lstm_sequencer

Host-side driver for the `lstm` cell: loads gate weights and biases, streams a sequence of `x` samples into the cell under its `ready` rule, and collects `y_out`/`C_out` into an output FIFO with valid/ready backpressure. Sits between a host stream source and one `lstm` instance.
- Zeroes the recurrent state (`h`, `C`) at the start of every sequence.
- Within a sequence, relies on the cell's internal feedback of `y_out`/`C_out`.

## Interface
- `WIDTH`, 16, sample, weight and output width, signed Q8.8.
- `OUT_DEPTH`, 4, output FIFO entries, power of two, ≥2.
- `WEIGHTS`, fixed local 4, gate order i,f,g,o (index 0..3).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1, `cfg_ready` out 1: config write handshake.
- `cfg_sel` in 2: 0 weight_x, 1 weight_h, 2 bias_x, 3 bias_h.
- `cfg_gate` in 2: gate index.
- `cfg_data` in WIDTH: value to write.
- `s_valid` in 1, `s_ready` out 1, `s_data` in WIDTH: input sample stream.
- `s_last` in 1: marks the final sample of a sequence.
- `m_valid` out 1, `m_ready` in 1: output stream handshake.
- `m_y` out WIDTH, `m_c` out WIDTH: cell outputs.
- `m_last` out 1: last-of-sequence tag.
- `lstm_weight_x`/`_h`, `lstm_bias_x`/`_h` out 4×WIDTH, with `*_valid` out 4 each: drive the cell.
- `lstm_x_in`/`lstm_h_in`/`lstm_c_in` out WIDTH, with `*_valid` out 1 each.
- `lstm_ready` in 1, `lstm_y_out` in WIDTH, `lstm_c_out` in WIDTH, `lstm_valid` in 1: from the cell.
- `busy` out 1: sample in flight or FIFO non-empty.
- `seq_cnt` out 16: completed sequences, wraps.
- `err_unexpected` out 1: sticky error flag.

## Operation
State:
- `in_flight` (0/1).
- `first` (sequence start pending, reset 1).
- `tag_last`.
- FIFO of {y, C, last} with count.
- `seq_cnt`.
- `err_unexpected`.

Config write (combinational drive, one-cycle pulse):
- `cfg_ready = lstm_ready & !in_flight`.
- On `cfg_valid & cfg_ready`, assert exactly one bit `[cfg_gate]` of the `*_valid` vector selected by `cfg_sel`. Put `cfg_data` on that lane; all other lanes are 0.

Sample issue:
- `s_ready = lstm_ready & !in_flight & (count < OUT_DEPTH) & !cfg_valid`. Config has priority.
- On accept:
  - `lstm_x_in_valid = 1`, `lstm_x_in = s_data`.
  - If `first`: also `lstm_h_in_valid = lstm_c_in_valid = 1` with data 0.
  - Set `in_flight`, `tag_last <= s_last`, `first <= s_last`.
- Otherwise all `lstm_*_valid` are 0 and data is 0.

Completion:
- On `lstm_valid & in_flight`: push {`lstm_y_out`, `lstm_c_out`, `tag_last`}, clear `in_flight`.
- If `tag_last`, increment `seq_cnt`.
- FIFO overflow is impossible: a slot is reserved at issue.
- `lstm_valid` while `!in_flight`: dropped, and `err_unexpected` is set (cleared only by reset).

FIFO:
- First-word-fall-through from registered storage.
- Pop on `m_valid & m_ready`.
- Simultaneous push and pop keeps count unchanged.
- Read/write pointers wrap modulo `OUT_DEPTH`.

Widths: no arithmetic on the data path. `seq_cnt` wraps 0xFFFF→0.

## Timing
- Reset (async assert, sync release): `m_valid=0`, `m_y=m_c=0`, `m_last=0`, all `lstm_*_valid=0`, `busy=0`, `seq_cnt=0`, `err_unexpected=0`, FIFO empty, `in_flight=0`, `first=1`.
- The cell must be reset concurrently; its reset is driven by the top level.
- Sample accepted at cycle T:
  - Cell `lstm_valid` at T+7, pushed at the T+7 edge.
  - `m_valid` high from T+8 (FIFO empty case).
  - `lstm_ready` returns at T+8, so the next `s_ready` is T+8 at the earliest.
- Peak throughput is one sample per 8 cycles.
- `s_ready` and `cfg_ready` are never high during an in-flight sample.
- A config write in the same cycle as a completion is legal only after `in_flight` clears, i.e. at T+8 or later.
- Reset mid-flight discards the in-flight sample and the FIFO contents.

## Test plan
- Reset with lstm model idle: all outputs 0, `s_ready=1`, `cfg_ready=1`. Assert `rst_n` low mid-idle → same values immediately, no clock required.
- Config: `cfg_sel=0`, `cfg_gate=1`, `cfg_data=0x0100` → same cycle `lstm_weight_x_valid=4'b0010`, `lstm_weight_x[1]=0x0100`, other lanes 0. During a sample in flight, `cfg_ready=0`.
- Sequence x=0x0100, 0x0080, 0xFF00 with `s_last` on the third:
  - First accept drives `h/c_in_valid=1` with data 0; the later two do not.
  - Accepts at T, T+8, T+16.
  - Outputs match the cell model; `m_last` is set only on the third; `seq_cnt=1`.
- Backpressure, `OUT_DEPTH=4`, `m_ready=0`, 6 samples offered: 4 complete, `s_ready` stays 0 afterward. One pop → `s_ready=1` next cycle.
- Back-to-back sequences of length 2 and 1: the first sample of each re-zeroes `h`/`C`; `seq_cnt` goes 0→1→2; `m_last` pattern is 0,1,1.
- Async reset at T+3 after an accept:
  - `m_valid` stays 0, FIFO is empty, `busy=0`.
  - A stray `lstm_valid` pulse at T+7 is dropped and `err_unexpected=1`.
